fd_checker: RTL

- Consumes the 512-bit AXI-stream test-data pattern (each beat is DW/16 identical 16-bit lanes holding an incrementing counter starting at 0) and checks it beat by beat.
- Applies a configurable backpressure pattern on tready.
- Counts accepted beats and errors, and captures the first failing beat.
- Sits directly downstream of the test-data generator, in the bench or on hardware, as the pass/fail endpoint.

---
 rtl/fd_checker.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/fd_checker.sv
// fd_checker: pass/fail endpoint for the AXI-stream test-data pattern.
// Every beat is expected to carry DW/16 identical 16-bit lanes holding an
// incrementing counter that starts at 0 after each start. The checker offers
// tready according to a rotating 8-slot stall mask. It counts accepted beats
// and mismatching beats, and records the first mismatching beat. After a
// mismatch the expected counter resynchronises to the received value, so a
// single dropped or duplicated beat is reported once rather than cascading.
module fd_checker #(
  parameter int         DW             = 512,
  parameter int         EXPECTED_BEATS = 1024,
  parameter logic [7:0] STALL_MASK     = 8'hFF
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [DW-1:0] axis_tdata,
  input  logic          axis_tvalid,
  output logic          axis_tready,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [31:0]   beat_count,
  output logic [15:0]   error_count,
  output logic [31:0]   first_err_beat,
  output logic [15:0]   first_err_data
);

  localparam int          LANES   = DW / 16;
  localparam logic        LIMITED = (EXPECTED_BEATS != 0);
  localparam logic [31:0] LIMIT   = 32'(EXPECTED_BEATS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Registered state.
  logic [1:0]  state_r;
  logic [2:0]  ptr_r;
  logic        tready_r;
  logic        busy_r;
  logic        done_r;
  logic [15:0] expected_r;
  logic [31:0] beat_count_r;
  logic [15:0] error_count_r;
  logic        error_r;
  logic [31:0] first_err_beat_r;
  logic [15:0] first_err_data_r;

  // Combinational helpers.
  logic [1:0]  next_state_s;
  logic        clear_s;
  logic        accept_s;
  logic [15:0] lane0_s;
  logic        uniform_s;
  logic        good_s;
  logic [31:0] beat_count_inc_s;
  logic        complete_s;
  logic [2:0]  ptr_next_s;
  logic        tready_next_s;
  logic [15:0] error_count_next_s;

  // True when every 16-bit lane of the beat carries the same value as lane 0.
  function automatic logic lanes_uniform(input logic [DW-1:0] data);
    logic same;
    same = 1'b1;
    for (int i = 1; i < LANES; i++) begin
      same = same & (data[i*16 +: 16] == data[15:0]);
    end
    return same;
  endfunction

  // Saturating increment for the 16-bit error counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

  assign accept_s           = (state_r == ST_CHECK) && axis_tvalid && tready_r;
  assign lane0_s            = axis_tdata[15:0];
  assign uniform_s          = lanes_uniform(axis_tdata);
  assign good_s             = uniform_s && (lane0_s == expected_r);
  assign beat_count_inc_s   = beat_count_r + 32'd1;
  assign complete_s         = accept_s && LIMITED && (beat_count_inc_s == LIMIT);
  assign error_count_next_s = sat_inc16(error_count_r);

  // Stall pointer restarts at slot 0 on every entry into CHECK, then rotates.
  assign ptr_next_s = (state_r == ST_CHECK) ? (ptr_r + 3'd1) : 3'd0;

  // Next-state selection; clear_s marks the edge that arms a new run.
  always_comb begin
    next_state_s = state_r;
    clear_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_state_s = ST_CHECK;
          clear_s      = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (complete_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_CHECK;
        end
      end
      ST_DONE: begin
        if (start) begin
          next_state_s = ST_CHECK;
          clear_s      = 1'b1;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
        clear_s      = 1'b0;
      end
    endcase
  end

  // Ready is only offered in CHECK, following the stall mask slot for the next cycle.
  always_comb begin
    tready_next_s = 1'b0;
    if (next_state_s == ST_CHECK) begin
      tready_next_s = STALL_MASK[ptr_next_s];
    end else begin
      tready_next_s = 1'b0;
    end
  end

  // Control registers: state, stall pointer, ready and run-status flags.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r  <= ST_IDLE;
      ptr_r    <= 3'd0;
      tready_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      ptr_r    <= ptr_next_s;
      tready_r <= tready_next_s;
      busy_r   <= (next_state_s == ST_CHECK);
      done_r   <= (next_state_s == ST_DONE);
    end
  end

  // Expected counter: advances on a good beat, resyncs to the received value on a bad one.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      expected_r <= 16'd0;
    end else if (clear_s) begin
      expected_r <= 16'd0;
    end else if (accept_s) begin
      if (good_s) begin
        expected_r <= expected_r + 16'd1;
      end else begin
        expected_r <= lane0_s + 16'd1;
      end
    end
  end

  // Beat counter and error accounting on each accepted beat.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      beat_count_r  <= 32'd0;
      error_count_r <= 16'd0;
      error_r       <= 1'b0;
    end else if (clear_s) begin
      beat_count_r  <= 32'd0;
      error_count_r <= 16'd0;
      error_r       <= 1'b0;
    end else if (accept_s) begin
      beat_count_r <= beat_count_inc_s;
      if (!good_s) begin
        error_count_r <= error_count_next_s;
        error_r       <= 1'b1;
      end
    end
  end

  // First-failure capture; only the first mismatch after start is recorded.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      first_err_beat_r <= 32'd0;
      first_err_data_r <= 16'd0;
    end else if (clear_s) begin
      first_err_beat_r <= 32'd0;
      first_err_data_r <= 16'd0;
    end else if (accept_s && !good_s && !error_r) begin
      first_err_beat_r <= beat_count_r;
      first_err_data_r <= lane0_s;
    end
  end

  assign axis_tready    = tready_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign error          = error_r;
  assign beat_count     = beat_count_r;
  assign error_count    = error_count_r;
  assign first_err_beat = first_err_beat_r;
  assign first_err_data = first_err_data_r;

endmodule
